// File: rtl/cache_mem_arbiter_pkg.sv
// Shared memory-bus types and arbiter constants for the cache/memory interconnect.
package cache_mem_arbiter_pkg;

  localparam int unsigned ARB_MAX_REQ = 8;
  localparam int unsigned ARB_IDX_W   = 3;
  localparam int unsigned MEM_ADDR_W  = 32;
  localparam int unsigned MEM_DATA_W  = 128;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic                  ready;
  } mem_data_type;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_type;

  // Index of the set bit in a one-hot vector (zero when none is set).
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_select.sv
// Round-robin picker: first valid requester at or after the pointer, as a one-hot grant.
module cache_mem_arbiter_rr_select #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               any_valid_o
);

  always_comb begin
    int unsigned        idx;
    logic [PTR_W-1:0]   sel;
    grant_o     = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr_i < NUM_REQ, so one subtraction is enough for the wrap
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!any_valid_o && valid_i[sel]) begin
        grant_o[sel] = 1'b1;
        any_valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between NUM_REQ cache controllers with round-robin grants,
// one whole transaction per grant, owner-only response routing and a stuck-memory watchdog.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  mem_req_type         req_i [NUM_REQ],
  output mem_data_type        rsp_o [NUM_REQ],
  output mem_req_type         mem_req_o,
  input  mem_data_type        mem_rsp_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);

  localparam mem_data_type TIMEOUT_RSP = '{data: '0, ready: 1'b1};

  arb_state_type      state_q;
  mem_req_type        mem_req_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [WD_W-1:0]    wd_q;

  logic [NUM_REQ-1:0] valid_vec_c;
  logic [NUM_REQ-1:0] sel_grant_c;
  logic               any_valid_c;
  logic [PTR_W-1:0]   sel_idx_c;
  logic [PTR_W-1:0]   owner_idx_c;
  logic [PTR_W-1:0]   ptr_d;
  mem_req_type        latch_req_c;
  logic               wd_expire_c;
  logic               release_c;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_valid
    assign valid_vec_c[k] = req_i[k].valid;
  end

  cache_mem_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .valid_i     (valid_vec_c),
    .ptr_i       (ptr_q),
    .grant_o     (sel_grant_c),
    .any_valid_o (any_valid_c)
  );

  assign sel_idx_c   = PTR_W'(onehot_to_idx(ARB_MAX_REQ'(sel_grant_c)));
  assign owner_idx_c = PTR_W'(onehot_to_idx(ARB_MAX_REQ'(grant_q)));
  assign ptr_d       = (owner_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx_c + PTR_W'(1);

  always_comb begin
    latch_req_c       = req_i[sel_idx_c];
    latch_req_c.valid = 1'b1;
  end

  // Real memory data beats an expiry landing in the same cycle.
  assign wd_expire_c = WD_EN && (state_q == ARB_BUSY) && !mem_rsp_i.ready &&
                       (wd_q == WD_W'(WD_LAST));
  assign release_c   = (state_q == ARB_BUSY) && (mem_rsp_i.ready || wd_expire_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      mem_req_q <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      wd_q      <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_valid_c) begin
            mem_req_q <= latch_req_c;
            grant_q   <= sel_grant_c;
            busy_q    <= 1'b1;
            wd_q      <= '0;
            state_q   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (release_c) begin
            mem_req_q.valid <= 1'b0;
            grant_q         <= '0;
            busy_q          <= 1'b0;
            ptr_q           <= ptr_d;
            wd_q            <= '0;
            state_q         <= ARB_IDLE;
          end else if (WD_EN) begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Response demux: only the owner sees memory; everyone else reads zero.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
    assign rsp_o[k] = !((state_q == ARB_BUSY) && grant_q[k]) ? '0 :
                      (wd_expire_c ? TIMEOUT_RSP : mem_rsp_i);
  end

  assign mem_req_o = mem_req_q;
  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign timeout_o = wd_expire_c;

endmodule
